// File: rtl/serial_word_deserializer_if.sv
// rtl/serial_word_deserializer_if.sv - serial-in / word-out handshake bundle for serial_word_deserializer
//
// Purpose: groups the serial input side and the parallel output side of the
// deserializer so they can be passed as a single port.
// Signals:
//   bit_in, bit_valid, bit_ready  serial bit handshake (bit_ready driven by the deserializer)
//   frame_clear                   discard the partially collected word
//   data_out, data_valid,         completed word handshake (data_ready driven by the consumer)
//   data_ready
//   bit_count                     bits collected in the current word
// Modports: master = source/consumer side, slave = deserializer side.

interface serial_word_deserializer_if #(
    parameter int width = 8
);
    localparam int cw = $clog2(width);

    logic             bit_in;
    logic             bit_valid;
    logic             bit_ready;
    logic             frame_clear;
    logic [width-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic [cw-1:0]    bit_count;

    modport master (
        output bit_in,
        output bit_valid,
        output frame_clear,
        output data_ready,
        input  bit_ready,
        input  data_out,
        input  data_valid,
        input  bit_count
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        input  frame_clear,
        input  data_ready,
        output bit_ready,
        output data_out,
        output data_valid,
        output bit_count
    );
endinterface

// File: rtl/serial_word_deserializer.sv
// rtl/serial_word_deserializer.sv - MSB-first serial bit collector producing width-bit words on a registered valid/ready port
//
// Purpose: shifts accepted serial bits into a word; each completed word is
// loaded into a one-deep output register presented with valid/ready.
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  asynchronous, active-high reset
//   bus      serial_word_deserializer_if.slave (bit handshake, frame_clear,
//            word handshake, bit_count)

module serial_word_deserializer #(
    parameter int width = 8
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    serial_word_deserializer_if.slave    bus
);
    localparam int            cw     = $clog2(width);
    localparam logic [cw-1:0] c_last = cw'(width - 1);
    localparam logic [cw-1:0] c_one  = cw'(1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [width-1:0] r_shift;
    logic [width-1:0] r_data_out;
    logic [cw-1:0]    r_bit_count;

    logic             w_data_valid;
    logic             w_bit_ready;
    logic             w_accept;
    logic             w_last_bit;
    logic             w_complete;
    logic             w_drain;
    logic [width-1:0] w_shift_next;

    assign w_last_bit   = (r_bit_count == c_last);
    assign w_drain      = w_data_valid && bus.data_ready;
    // Only the word-closing bit has to wait for room in the output register;
    // earlier bits land in the shift register, which is independent of it.
    assign w_bit_ready  = !i_reset && !bus.frame_clear &&
                          !(w_last_bit && w_data_valid && !bus.data_ready);
    assign w_accept     = bus.bit_valid && w_bit_ready;
    assign w_complete   = w_accept && w_last_bit;
    assign w_shift_next = {r_shift[width-2:0], bus.bit_in};

    // Output register state
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A completing word wins over a drain so drain+load leaves no bubble.
    always_comb begin
        w_state_next = r_state;
        if (w_complete) begin
            w_state_next = ST_FULL;
        end else if (w_drain) begin
            w_state_next = ST_EMPTY;
        end
    end

    always_comb begin
        w_data_valid = 1'b0;
        if (r_state == ST_FULL) begin
            w_data_valid = 1'b1;
        end
    end

    // Serial collection and word load
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shift     <= '0;
            r_bit_count <= '0;
            r_data_out  <= '0;
        end else begin
            if (bus.frame_clear) begin
                r_shift     <= '0;
                r_bit_count <= '0;
            end else if (w_accept) begin
                r_shift     <= w_shift_next;
                r_bit_count <= w_last_bit ? '0 : r_bit_count + c_one;
            end
            // data_out is left untouched on drain; it only changes on a new word.
            if (w_complete) begin
                r_data_out <= w_shift_next;
            end
        end
    end

    assign bus.bit_ready  = w_bit_ready;
    assign bus.data_valid = w_data_valid;
    assign bus.data_out   = r_data_out;
    assign bus.bit_count  = r_bit_count;
endmodule

// File: tb/tb_serial_word_deserializer.sv
// tb/tb_serial_word_deserializer.sv - self-checking bench for serial_word_deserializer (width 4 and width 8 side by side)

module tb_serial_word_deserializer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tb_bit_in = 1'b0;
    logic tb_bit_valid = 1'b0;
    logic tb_frame_clear = 1'b0;
    logic tb_data_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_word_deserializer_if #(.width(4)) if4 ();
    serial_word_deserializer_if #(.width(8)) if8 ();

    assign if4.bit_in      = tb_bit_in;
    assign if4.bit_valid   = tb_bit_valid;
    assign if4.frame_clear = tb_frame_clear;
    assign if4.data_ready  = tb_data_ready;
    assign if8.bit_in      = tb_bit_in;
    assign if8.bit_valid   = tb_bit_valid;
    assign if8.frame_clear = tb_frame_clear;
    assign if8.data_ready  = tb_data_ready;

    serial_word_deserializer #(.width(4)) u_dut4 (.i_clk(clk), .i_reset(rst), .bus(if4));
    serial_word_deserializer #(.width(8)) u_dut8 (.i_clk(clk), .i_reset(rst), .bus(if8));

    // Reference model: partial word kept as a list of bits, output as a held word plus a full flag.
    int          m_w[2] = '{4, 8};
    int          m_bits[2][$];
    bit          m_full[2];
    logic [31:0] m_word[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_ready(input int k);
        return (k == 0) ? 32'(if4.bit_ready) : 32'(if8.bit_ready);
    endfunction
    function automatic logic [31:0] dut_valid(input int k);
        return (k == 0) ? 32'(if4.data_valid) : 32'(if8.data_valid);
    endfunction
    function automatic logic [31:0] dut_dout(input int k);
        return (k == 0) ? 32'(if4.data_out) : 32'(if8.data_out);
    endfunction
    function automatic logic [31:0] dut_count(input int k);
        return (k == 0) ? 32'(if4.bit_count) : 32'(if8.bit_count);
    endfunction

    function automatic bit model_ready(input int k, input bit fc, input bit dr);
        return !fc && !(m_bits[k].size() == m_w[k] - 1 && m_full[k] && !dr);
    endfunction

    function automatic logic [31:0] word_of(input int k);
        logic [31:0] w = 0;
        foreach (m_bits[k][i]) w = w * 2 + 32'(m_bits[k][i]);
        return w;
    endfunction

    task automatic check_regs(input string when);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_valid_w%0d", when, m_w[k]), dut_valid(k), 32'(m_full[k]));
            check($sformatf("%s_dout_w%0d", when, m_w[k]), dut_dout(k), m_word[k]);
            check($sformatf("%s_count_w%0d", when, m_w[k]), dut_count(k), 32'(m_bits[k].size()));
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle(input bit bi, input bit bv, input bit fc, input bit dr);
        bit acc[2];
        bit xfer[2];
        tb_bit_in = bi;
        tb_bit_valid = bv;
        tb_frame_clear = fc;
        tb_data_ready = dr;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("bit_ready_w%0d", m_w[k]), dut_ready(k), 32'(model_ready(k, fc, dr)));
            acc[k]  = bv && model_ready(k, fc, dr);
            xfer[k] = m_full[k] && dr;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            bit done = 1'b0;
            if (fc) begin
                m_bits[k].delete();
            end else if (acc[k]) begin
                m_bits[k].push_back(int'(bi));
                if (m_bits[k].size() == m_w[k]) begin
                    m_word[k] = word_of(k);
                    m_full[k] = 1'b1;
                    m_bits[k].delete();
                    done = 1'b1;
                end
            end
            if (!done && xfer[k]) m_full[k] = 1'b0;
        end
        check_regs("post");
    endtask

    task automatic feed(input logic [31:0] bits, input int n, input bit dr);
        for (int i = 0; i < n; i++) begin
            logic [31:0] b = bits;
            cycle(b[n-1-i], 1'b1, 1'b0, dr);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tb_bit_valid = 1'b0;
        tb_frame_clear = 1'b0;
        tb_data_ready = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            m_bits[k].delete();
            m_full[k] = 1'b0;
            m_word[k] = 0;
            check($sformatf("rst_bit_ready_w%0d", m_w[k]), dut_ready(k), 32'd0);
        end
        check_regs("rst");
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_bit_ready", dut_ready(0), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        #1;
        // 1: reset, then bit_ready must come up the first cycle after
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_ready_after_rst", 32'(if4.bit_ready), 32'd1);

        // 2: 1011 with data_ready=1, valid for exactly one cycle
        feed(32'b1011, 4, 1'b1);
        check("t2_dout", 32'(if4.data_out), 32'hb);
        check("t2_valid", 32'(if4.data_valid), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_valid_drop", 32'(if4.data_valid), 32'd0);

        // 3: hold 1011, collect 011, final bit stalls until data_ready
        feed(32'b1011, 4, 1'b0);
        feed(32'b011, 3, 1'b0);
        check("t3_count", 32'(if4.bit_count), 32'd3);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_still_held", 32'(if4.data_out), 32'hb);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("t3_dout", 32'(if4.data_out), 32'h6);
        check("t3_valid", 32'(if4.data_valid), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // 4: partial word discarded by frame_clear
        feed(32'b11, 2, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("t4_count_clr", 32'(if4.bit_count), 32'd0);
        feed(32'b1100, 4, 1'b1);
        check("t4_dout", 32'(if4.data_out), 32'hc);
        check("t4_valid", 32'(if4.data_valid), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // 5: reset while holding a word and 3 bits
        feed(32'b1011, 4, 1'b0);
        feed(32'b111, 3, 1'b0);
        do_reset();
        feed(32'b0001, 4, 1'b1);
        check("t5_dout", 32'(if4.data_out), 32'h1);

        // 6: continuous stream, bit_ready must never drop
        feed(32'h0b69, 12, 1'b1);
        check("t6_dout", 32'(if4.data_out), 32'h9);
        for (int i = 0; i < 24; i++) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);

        // Random traffic with backpressure and occasional clears
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
